fir_output_stage: RTL

//   Downstream of the last transposed-tap stage of the FIR chain. Captures the final tap's

---
 rtl/fir_output_stage_if.sv | 28 ++
 rtl/fir_output_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fir_output_stage_if.sv
// rtl/fir_output_stage_if.sv - sum input and valid/ready sample output of the FIR output stage
// The master side drives sums and the consumer ready; the slave side is the output stage.
interface fir_output_stage_if #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 16
);
   logic                  i_sum_valid;
   logic [DATA_WIDTH-1:0] iv_sum;
   logic                  o_valid;
   logic                  i_ready;
   logic [OUT_WIDTH-1:0]  ov_dout;

   modport master (
      output i_sum_valid,
      output iv_sum,
      output i_ready,
      input  o_valid,
      input  ov_dout
   );

   modport slave (
      input  i_sum_valid,
      input  iv_sum,
      input  i_ready,
      output o_valid,
      output ov_dout
   );
endinterface

// File: rtl/fir_output_stage.sv
// rtl/fir_output_stage.sv - FIR output stage: decimate, round/saturate, FWFT output FIFO
// Stage 1 never stalls; a result that finds the FIFO full with no pop is dropped and flagged.
module fir_output_stage #(
   parameter int DATA_WIDTH = 32,
   parameter int OUT_WIDTH  = 16,
   parameter int DECIM      = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_clr,
   fir_output_stage_if.slave             bus,
   output logic [$clog2(FIFO_DEPTH):0]   ov_level,
   output logic                          o_overflow,
   output logic                          o_sat
);
   localparam int SH = DATA_WIDTH - OUT_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic signed [DATA_WIDTH:0] C_RND =
      {{(DATA_WIDTH + 1 - SH){1'b0}}, 1'b1, {(SH - 1){1'b0}}};
   localparam logic signed [DATA_WIDTH:0] C_MAX = {{(SH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
   localparam logic signed [DATA_WIDTH:0] C_MIN = {{(SH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};
   localparam logic [7:0]    C_DLAST = 8'(DECIM - 1);
   localparam logic [AW:0]   C_FULL  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW-1:0] C_ONE   = {{(AW - 1){1'b0}}, 1'b1};

   logic [7:0]            r_cnt;
   logic                  r_s1_valid;
   logic [OUT_WIDTH-1:0]  r_s1_data;
   logic [OUT_WIDTH-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wptr;
   logic [AW-1:0]         r_rptr;
   logic [AW:0]           r_level;
   logic [OUT_WIDTH-1:0]  r_last;
   logic                  r_ovf;
   logic                  r_sat;

   logic                  w_keep;
   logic signed [DATA_WIDTH:0] w_t;
   logic signed [DATA_WIDTH:0] w_r;
   logic                  w_hi;
   logic                  w_lo;
   logic [OUT_WIDTH-1:0]  w_result;
   logic                  w_pop;
   logic                  w_push;

   assign w_keep = bus.i_sum_valid && (r_cnt == 8'd0);

   // One extra bit of headroom so the rounding add cannot wrap at the positive end.
   assign w_t = $signed({bus.iv_sum[DATA_WIDTH-1], bus.iv_sum}) + C_RND;
   assign w_r = w_t >>> SH;
   assign w_hi = (w_r > C_MAX);
   assign w_lo = (w_r < C_MIN);
   assign w_result = w_hi ? C_MAX[OUT_WIDTH-1:0] :
                     w_lo ? C_MIN[OUT_WIDTH-1:0] : w_r[OUT_WIDTH-1:0];

   assign w_pop  = (r_level != '0) && bus.i_ready;
   assign w_push = r_s1_valid && ((r_level < C_FULL) || w_pop);

   assign bus.o_valid = (r_level != '0);
   assign bus.ov_dout = (r_level != '0) ? r_mem[r_rptr] : r_last;
   assign ov_level    = r_level;
   assign o_overflow  = r_ovf;
   assign o_sat       = r_sat;

   always_ff @(posedge i_clk) begin
      if (w_push && !i_clr) begin
         r_mem[r_wptr] <= r_s1_data;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_last     <= '0;
         r_ovf      <= 1'b0;
         r_sat      <= 1'b0;
      end else if (i_clr) begin
         r_cnt      <= '0;
         r_s1_valid <= 1'b0;
         r_s1_data  <= '0;
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_last     <= '0;
         r_ovf      <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         if (bus.i_sum_valid) begin
            r_cnt <= (r_cnt == C_DLAST) ? 8'd0 : r_cnt + 8'd1;
         end
         r_s1_valid <= w_keep;
         if (w_keep) begin
            r_s1_data <= w_result;
            if (w_hi || w_lo) begin
               r_sat <= 1'b1;
            end
         end
         if (w_push) begin
            r_wptr <= r_wptr + C_ONE;
         end
         // Remember the departing head so ov_dout holds it once the FIFO drains.
         if (w_pop) begin
            r_rptr <= r_rptr + C_ONE;
            r_last <= r_mem[r_rptr];
         end
         if (r_s1_valid && !w_push) begin
            r_ovf <= 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end
endmodule
